// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_lvl FIFO: width derivation,
// wrapping pointer increment and the sticky error flag layout.
package fifo_pkg;

  function automatic int cnt_w(input int entries);
    return $clog2(entries + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Explicit wrap so any depth works, not only powers of two.
  function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input int depth);
    return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
  endfunction

  typedef enum logic [0:0] {
    ERR_UNDERFLOW = 1'b0,
    ERR_OVERFLOW  = 1'b1
  } err_bit_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

endpackage

// File: rtl/fifo_lvl_ptr.sv
// Wrapping pointer counter for fifo_lvl; advances by one on inc_i and
// wraps from DEPTH-1 back to 0.
module fifo_lvl_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = PTR_W'(ptr_next(32'(ptr_q), DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_lvl.sv
// Synchronous FIFO with arbitrary depth, occupancy count, runtime level
// thresholds and sticky error flags. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_lvl
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ENTRIES_N = 4,
  localparam int CNT_W    = cnt_w(ENTRIES_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic [CNT_W-1:0]  afull_thresh_i,
  input  logic [CNT_W-1:0]  aempty_thresh_i,
  input  logic              err_clr_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              afull_o,
  output logic              aempty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int PTR_W = ptr_w(ENTRIES_N);

  logic [DATA_W-1:0] mem_q [ENTRIES_N];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q, afull_q, aempty_q;
  err_flags_t        err_q, err_d;
  logic              wr_accept, rd_accept;

  // Accepts are decided from registered state only; a pop frees room for a push when full.
  assign rd_accept = rd_i & ~empty_q;
  assign wr_accept = wr_i & (~full_q | rd_accept);

  fifo_lvl_ptr #(.DEPTH(ENTRIES_N)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (wr_accept),
    .ptr_o (wr_ptr)
  );

  fifo_lvl_ptr #(.DEPTH(ENTRIES_N)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (rd_accept),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A set event in the same cycle as a clear keeps the flag high.
  always_comb begin
    err_d.overflow  = (err_q.overflow  & ~err_clr_i) | (wr_i & ~wr_accept);
    err_d.underflow = (err_q.underflow & ~err_clr_i) | (rd_i & empty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (afull_thresh_i == '0);
      aempty_q <= 1'b1;
      err_q    <= '0;
    end else begin
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(ENTRIES_N));
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= afull_thresh_i);
      aempty_q <= (count_d <= aempty_thresh_i);
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr] <= wr_data_i;
  end

`ifdef FIFO_FWFT_EN
  assign rd_data_o  = empty_q ? '0 : mem_q[rd_ptr];
  assign rd_valid_o = ~empty_q;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) rd_data_q <= mem_q[rd_ptr];
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`endif

  assign count_o     = count_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign afull_o     = afull_q;
  assign aempty_o    = aempty_q;
  assign overflow_o  = err_q.overflow;
  assign underflow_o = err_q.underflow;

endmodule

// File: tb/tb_fifo_lvl.sv
// Directed bench for fifo_lvl: a 4-entry and a 5-entry instance share the
// same stimulus; each scenario task checks the instance it targets.
module tb_fifo_lvl;

  localparam int DW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr, rd, err_clr;
  logic [DW-1:0] wdata;
  logic [CW-1:0] af_th, ae_th;

  logic [DW-1:0] rd_data4, rd_data5;
  logic          rd_valid4, rd_valid5, full4, full5, empty4, empty5;
  logic          afull4, afull5, aempty4, aempty5, ovf4, ovf5, unf4, unf5;
  logic [CW-1:0] count4, count5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_lvl #(.DATA_W(DW), .ENTRIES_N(4)) u_dut4 (
    .clk(clk), .reset(reset), .wr_i(wr), .wr_data_i(wdata), .rd_i(rd),
    .rd_data_o(rd_data4), .rd_valid_o(rd_valid4), .afull_thresh_i(af_th),
    .aempty_thresh_i(ae_th), .err_clr_i(err_clr), .full_o(full4), .empty_o(empty4),
    .afull_o(afull4), .aempty_o(aempty4), .count_o(count4),
    .overflow_o(ovf4), .underflow_o(unf4)
  );

  fifo_lvl #(.DATA_W(DW), .ENTRIES_N(5)) u_dut5 (
    .clk(clk), .reset(reset), .wr_i(wr), .wr_data_i(wdata), .rd_i(rd),
    .rd_data_o(rd_data5), .rd_valid_o(rd_valid5), .afull_thresh_i(af_th),
    .aempty_thresh_i(ae_th), .err_clr_i(err_clr), .full_o(full5), .empty_o(empty5),
    .afull_o(afull5), .aempty_o(aempty5), .count_o(count5),
    .overflow_o(ovf5), .underflow_o(unf5)
  );

  // Inputs change and outputs are observed 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    wdata = '0; af_th = 3'd3; ae_th = 3'd1;
    do_reset();
    cyc();
    checks++; if (empty4 !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b exp 1", empty4); end
    checks++; if (full4 !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b exp 0", full4); end
    checks++; if (count4 !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count4); end
    checks++; if (aempty4 !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %0b exp 1", aempty4); end
    checks++; if (afull4 !== 1'b0) begin errors++; $display("FAIL reset_afull: got %0b exp 0", afull4); end
    checks++; if ({ovf4, unf4} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b exp 00", {ovf4, unf4}); end
    checks++; if ({rd_valid4, rd_data4} !== 9'd0) begin errors++; $display("FAIL reset_rd: got %0b/%0h exp 0/0", rd_valid4, rd_data4); end
  endtask

  task automatic test_fill_overflow();
    logic [DW-1:0] vals [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; wdata = vals[i];
      cyc();
      checks++; if (count4 !== CW'(i + 1)) begin errors++; $display("FAIL fill_count%0d: got %0d exp %0d", i, count4, i + 1); end
      checks++; if (afull4 !== (i + 1 >= 3)) begin errors++; $display("FAIL fill_afull%0d: got %0b exp %0b", i, afull4, (i + 1 >= 3)); end
    end
    checks++; if (full4 !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b exp 1", full4); end
    wdata = 8'hE5;
    cyc();
    wr = 1'b0;
    checks++; if (ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b exp 1", ovf4); end
    checks++; if (count4 !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d exp 4", count4); end
  endtask

  task automatic test_drain_underflow();
    logic [DW-1:0] vals [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef FIFO_FWFT_EN
      checks++; if ({rd_valid4, rd_data4} !== {1'b1, vals[i]}) begin errors++; $display("FAIL drain_head%0d: got %0b/%0h exp 1/%0h", i, rd_valid4, rd_data4, vals[i]); end
      cyc();
`else
      cyc();
      checks++; if ({rd_valid4, rd_data4} !== {1'b1, vals[i]}) begin errors++; $display("FAIL drain_data%0d: got %0b/%0h exp 1/%0h", i, rd_valid4, rd_data4, vals[i]); end
`endif
      checks++; if (count4 !== CW'(3 - i)) begin errors++; $display("FAIL drain_count%0d: got %0d exp %0d", i, count4, 3 - i); end
    end
    cyc();
    rd = 1'b0;
    checks++; if (unf4 !== 1'b1) begin errors++; $display("FAIL unf_set: got %0b exp 1", unf4); end
    checks++; if (rd_valid4 !== 1'b0) begin errors++; $display("FAIL unf_valid: got %0b exp 0", rd_valid4); end
`ifdef FIFO_FWFT_EN
    checks++; if (rd_data4 !== 8'h00) begin errors++; $display("FAIL unf_data: got %0h exp 00", rd_data4); end
`else
    checks++; if (rd_data4 !== 8'hD4) begin errors++; $display("FAIL unf_data_hold: got %0h exp d4", rd_data4); end
`endif
    checks++; if (ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b exp 1", ovf4); end
    err_clr = 1'b1;
    cyc();
    checks++; if ({ovf4, unf4} !== 2'b00) begin errors++; $display("FAIL err_clr: got %b exp 00", {ovf4, unf4}); end
    rd = 1'b1;
    cyc();
    rd = 1'b0; err_clr = 1'b0;
    checks++; if (unf4 !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %0b exp 1", unf4); end
  endtask

  task automatic test_wrap();
    af_th = 3'd4; ae_th = 3'd1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      wr = 1'b1; wdata = DW'(8'h10 + k);
      cyc();
      checks++; if (count5 !== CW'(k + 1)) begin errors++; $display("FAIL wrap_fill_count%0d: got %0d exp %0d", k, count5, k + 1); end
      checks++; if (afull5 !== (k + 1 >= 4)) begin errors++; $display("FAIL wrap_afull%0d: got %0b exp %0b", k, afull5, (k + 1 >= 4)); end
      checks++; if (aempty5 !== (k + 1 <= 1)) begin errors++; $display("FAIL wrap_aempty%0d: got %0b exp %0b", k, aempty5, (k + 1 <= 1)); end
    end
    checks++; if (full5 !== 1'b1) begin errors++; $display("FAIL wrap_full: got %0b exp 1", full5); end
    for (int i = 0; i < 12; i++) begin
      wr = 1'b1; rd = 1'b1; wdata = DW'(8'h15 + i);
`ifdef FIFO_FWFT_EN
      checks++; if (rd_data5 !== DW'(8'h10 + i)) begin errors++; $display("FAIL stream_head%0d: got %0h exp %0h", i, rd_data5, 8'h10 + i); end
      cyc();
`else
      cyc();
      checks++; if ({rd_valid5, rd_data5} !== {1'b1, DW'(8'h10 + i)}) begin errors++; $display("FAIL stream_data%0d: got %0b/%0h exp 1/%0h", i, rd_valid5, rd_data5, 8'h10 + i); end
`endif
      checks++; if ({count5, ovf5} !== {3'd5, 1'b0}) begin errors++; $display("FAIL stream_cnt_ovf%0d: got %0d/%0b exp 5/0", i, count5, ovf5); end
    end
    wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
`ifdef FIFO_FWFT_EN
      checks++; if (rd_data5 !== DW'(8'h1C + i)) begin errors++; $display("FAIL wrap_drain_head%0d: got %0h exp %0h", i, rd_data5, 8'h1C + i); end
      cyc();
`else
      cyc();
      checks++; if (rd_data5 !== DW'(8'h1C + i)) begin errors++; $display("FAIL wrap_drain_data%0d: got %0h exp %0h", i, rd_data5, 8'h1C + i); end
`endif
      checks++; if (count5 !== CW'(4 - i)) begin errors++; $display("FAIL wrap_drain_count%0d: got %0d exp %0d", i, count5, 4 - i); end
      checks++; if ({afull5, aempty5} !== {(4 - i >= 4), (4 - i <= 1)}) begin errors++; $display("FAIL wrap_levels%0d: got %b exp %b", i, {afull5, aempty5}, {(4 - i >= 4), (4 - i <= 1)}); end
    end
    rd = 1'b0;
  endtask

  task automatic test_empty_simul();
    wr = 1'b1; rd = 1'b1; wdata = 8'h77;
    cyc();
    wr = 1'b0;
    checks++; if (count5 !== 3'd1) begin errors++; $display("FAIL empty_simul_count: got %0d exp 1", count5); end
    checks++; if ({unf5, ovf5} !== 2'b10) begin errors++; $display("FAIL empty_simul_errs: got %b exp 10", {unf5, ovf5}); end
`ifdef FIFO_FWFT_EN
    checks++; if ({rd_valid5, rd_data5} !== {1'b1, 8'h77}) begin errors++; $display("FAIL empty_simul_head: got %0b/%0h exp 1/77", rd_valid5, rd_data5); end
    cyc();
    checks++; if ({rd_valid5, count5} !== {1'b0, 3'd0}) begin errors++; $display("FAIL empty_simul_pop: got %0b/%0d exp 0/0", rd_valid5, count5); end
`else
    checks++; if (rd_valid5 !== 1'b0) begin errors++; $display("FAIL empty_simul_valid: got %0b exp 0", rd_valid5); end
    cyc();
    checks++; if ({rd_valid5, rd_data5, count5} !== {1'b1, 8'h77, 3'd0}) begin errors++; $display("FAIL empty_simul_pop: got %0b/%0h/%0d exp 1/77/0", rd_valid5, rd_data5, count5); end
`endif
    rd = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; wdata = DW'(8'h30 + i);
      cyc();
    end
    checks++; if (count4 !== 3'd3) begin errors++; $display("FAIL midrst_pre_count: got %0d exp 3", count4); end
    reset = 1'b1; wr = 1'b1; rd = 1'b1;
    cyc();
    reset = 1'b0; wr = 1'b0; rd = 1'b0;
    checks++; if ({empty4, full4, count4} !== {1'b1, 1'b0, 3'd0}) begin errors++; $display("FAIL midrst_state: got %b exp 1_0_000", {empty4, full4, count4}); end
    checks++; if (rd_valid4 !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b exp 0", rd_valid4); end
    checks++; if (afull4 !== 1'b0) begin errors++; $display("FAIL midrst_afull: got %0b exp 0", afull4); end
  endtask

  task automatic test_thresh_change();
    af_th = 3'd0; ae_th = 3'd0;
    cyc();
    checks++; if ({afull4, aempty4} !== 2'b11) begin errors++; $display("FAIL thresh_change: got %b exp 11", {afull4, aempty4}); end
    af_th = 3'd4;
    cyc();
    checks++; if (afull4 !== 1'b0) begin errors++; $display("FAIL thresh_restore: got %0b exp 0", afull4); end
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    do_reset();
    wr = 1'b1; wdata = 8'h5A;
    cyc();
    wr = 1'b0;
    checks++; if ({rd_valid4, rd_data4} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL fwft_show: got %0b/%0h exp 1/5a", rd_valid4, rd_data4); end
    cyc();
    checks++; if ({rd_valid4, rd_data4, count4} !== {1'b1, 8'h5A, 3'd1}) begin errors++; $display("FAIL fwft_hold: got %0b/%0h/%0d exp 1/5a/1", rd_valid4, rd_data4, count4); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_wrap();
    test_empty_simul();
    test_mid_reset();
    test_thresh_change();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
